// File: rtl/mspe_egress_arb.sv
// Round-robin egress arbiter: picks a sop-headed channel and streams its packet to one Avalon-ST source.
// Latency: 1 cycle from channel beat accept to src_valid; 1 idle selection cycle between packets.
// Backpressure: single output register, loads only when !src_valid | src_ready; ch_ready[g] follows that.
module mspe_egress_arb #(
    parameter int CHANNELS  = 4,
    parameter int DATA_W    = 512,
    parameter int MAX_BEATS = 256,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS*DATA_W-1:0] ch_data,
    input  logic [CHANNELS-1:0]        ch_valid,
    input  logic [CHANNELS-1:0]        ch_sop,
    input  logic [CHANNELS-1:0]        ch_eop,
    output logic [CHANNELS-1:0]        ch_ready,
    input  logic [CHANNELS-1:0]        ch_enable,
    output logic [DATA_W-1:0]          src_data,
    output logic                       src_valid,
    output logic                       src_sop,
    output logic                       src_eop,
    output logic [CW-1:0]              src_channel,
    input  logic                       src_ready,
    output logic [CHANNELS*32-1:0]     pkt_count,
    output logic [15:0]                trunc_count,
    output logic [15:0]                drop_count
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       g_q, g_d;
    logic [CW-1:0]       last_q, last_d;
    logic [BW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   src_data_q, src_data_d;
    logic                src_valid_q, src_valid_d;
    logic                src_sop_q, src_sop_d;
    logic                src_eop_q, src_eop_d;
    logic [CW-1:0]       src_channel_q, src_channel_d;
    logic [31:0]         pkt_q [CHANNELS];
    logic [31:0]         pkt_d [CHANNELS];
    logic [15:0]         trunc_q, trunc_d;
    logic [15:0]         drop_q, drop_d;

    logic [DATA_W-1:0]   ch_data_a [CHANNELS];
    logic [CHANNELS-1:0] ready_c;
    logic                load_ok;
    logic                sel_found, orph_found;
    logic [CW-1:0]       sel_idx, orph_idx, cand;
    logic [DATA_W-1:0]   g_data;
    logic                g_valid, g_eop, last_beat;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_data_a[k]            = ch_data[k*DATA_W +: DATA_W];
        assign pkt_count[k*32 +: 32]   = pkt_q[k];
    end

    assign g_data    = ch_data_a[g_q];
    assign g_valid   = ch_valid[g_q];
    assign g_eop     = ch_eop[g_q];
    assign load_ok   = !src_valid_q || src_ready;
    assign last_beat = (cnt_q == BW'(MAX_BEATS - 1));

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = CW'((int'(last_q) + i) % CHANNELS);
            if (!sel_found && ch_valid[cand] && ch_sop[cand] && ch_enable[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Lowest-index enabled channel presenting a beat that cannot start a packet.
    always_comb begin
        orph_found = 1'b0;
        orph_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (ch_enable[k] && ch_valid[k] && !ch_sop[k]) begin
                orph_found = 1'b1;
                orph_idx   = CW'(k);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        src_data_d    = src_data_q;
        src_valid_d   = src_valid_q;
        src_sop_d     = src_sop_q;
        src_eop_d     = src_eop_q;
        src_channel_d = src_channel_q;
        pkt_d         = pkt_q;
        trunc_d       = trunc_q;
        drop_d        = drop_q;
        ready_c       = '0;

        if (load_ok) begin
            src_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    g_d     = sel_idx;
                    last_d  = sel_idx;
                    cnt_d   = '0;
                    state_d = XFER;
                end else if (orph_found) begin
                    ready_c[orph_idx] = 1'b1;
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            XFER: begin
                ready_c[g_q] = load_ok;
                if (load_ok && g_valid) begin
                    src_data_d    = g_data;
                    src_valid_d   = 1'b1;
                    src_channel_d = g_q;
                    src_sop_d     = (cnt_q == '0);
                    src_eop_d     = g_eop || last_beat;
                    cnt_d         = cnt_q + 1'b1;
                    if (g_eop || last_beat) begin
                        pkt_d[g_q] = pkt_q[g_q] + 32'd1;
                    end
                    if (g_eop) begin
                        state_d = IDLE;
                    end else if (last_beat) begin
                        // Oversized packet: close it on the wire, swallow the remainder.
                        state_d = DRAIN;
                        if (trunc_q != 16'hFFFF) begin
                            trunc_d = trunc_q + 16'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                ready_c[g_q] = 1'b1;
                if (g_valid && g_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            g_q           <= '0;
            last_q        <= CW'(CHANNELS - 1);
            cnt_q         <= '0;
            src_data_q    <= '0;
            src_valid_q   <= 1'b0;
            src_sop_q     <= 1'b0;
            src_eop_q     <= 1'b0;
            src_channel_q <= '0;
            trunc_q       <= '0;
            drop_q        <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                pkt_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            src_data_q    <= src_data_d;
            src_valid_q   <= src_valid_d;
            src_sop_q     <= src_sop_d;
            src_eop_q     <= src_eop_d;
            src_channel_q <= src_channel_d;
            trunc_q       <= trunc_d;
            drop_q        <= drop_d;
            pkt_q         <= pkt_d;
        end
    end

    assign ch_ready    = reset ? '0 : ready_c;
    assign src_data    = src_data_q;
    assign src_valid   = src_valid_q;
    assign src_sop     = src_sop_q;
    assign src_eop     = src_eop_q;
    assign src_channel = src_channel_q;
    assign trunc_count = trunc_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_mspe_egress_arb.sv
// Bench for mspe_egress_arb: per-channel beat queues feed the DUT, a packet-level
// round-robin model predicts the output beat stream and the counters.
module tb_mspe_egress_arb;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [1:0]    ch;
    } obeat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH*DW-1:0]  ch_data;
    logic [CH-1:0]     ch_valid, ch_sop, ch_eop, ch_ready, ch_enable;
    logic [DW-1:0]     src_data;
    logic              src_valid, src_sop, src_eop, src_ready;
    logic [1:0]        src_channel;
    logic [CH*32-1:0]  pkt_count;
    logic [15:0]       trunc_count, drop_count;

    mspe_egress_arb #(.CHANNELS(CH), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk(clk), .reset(reset),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_sop(ch_sop), .ch_eop(ch_eop),
        .ch_ready(ch_ready), .ch_enable(ch_enable),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_channel(src_channel), .src_ready(src_ready),
        .pkt_count(pkt_count), .trunc_count(trunc_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    beat_t         chq [CH][$];
    obeat_t        expq [$];
    int            sop_order [$];
    int            m_last, m_trunc, m_drop, exp_total;
    int            m_pkt [CH];
    int            seen_ch [CH];
    int            p0 [CH];
    int            n_tests, n_fail, cyc, beats_seen, last_eop_cyc, rdy_mode;
    int            b0, b2, s0, t;
    bit            gap_chk, any_vld;
    logic [CH-1:0] en;
    logic [DW-1:0] snap_d;
    logic          snap_s, snap_e;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(int k, int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = $urandom;
            b.sop  = (j == 0);
            b.eop  = (j == len - 1);
            chq[k].push_back(b);
        end
    endtask

    // Packet-level model: whole packets chosen round-robin, clipped to MB beats.
    task automatic predict();
        beat_t  q [CH][$];
        beat_t  b;
        obeat_t ob;
        int     k, n, c;
        bit     found, done;
        for (int i = 0; i < CH; i++) q[i] = chq[i];
        done = 1'b0;
        while (!done) begin
            found = 1'b0;
            k = 0;
            for (int i = 1; i <= CH; i++) begin
                c = (m_last + i) % CH;
                if (!found && en[c] && q[c].size() > 0 && q[c][0].sop) begin
                    found = 1'b1;
                    k = c;
                end
            end
            if (found) begin
                m_last = k;
                n = 0;
                do begin
                    b = q[k].pop_front();
                    n++;
                    if (n <= MB) begin
                        ob = {b.data, (n == 1), (b.eop || n == MB), 2'(k)};
                        expq.push_back(ob);
                        exp_total++;
                        if (n == MB && !b.eop) m_trunc++;
                        if (b.eop || n == MB) m_pkt[k]++;
                    end
                end while (!b.eop && q[k].size() > 0);
            end else begin
                for (int i = CH - 1; i >= 0; i--) begin
                    if (en[i] && q[i].size() > 0 && !q[i][0].sop) begin
                        found = 1'b1;
                        k = i;
                    end
                end
                if (found) begin
                    void'(q[k].pop_front());
                    m_drop++;
                end else begin
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic drive();
        for (int k = 0; k < CH; k++) begin
            if (chq[k].size() > 0) begin
                ch_valid[k]            = 1'b1;
                ch_sop[k]              = chq[k][0].sop;
                ch_eop[k]              = chq[k][0].eop;
                ch_data[k*DW +: DW]    = chq[k][0].data;
            end else begin
                ch_valid[k]            = 1'b0;
                ch_sop[k]              = 1'b0;
                ch_eop[k]              = 1'b0;
                ch_data[k*DW +: DW]    = '0;
            end
        end
        ch_enable = en;
        case (rdy_mode)
            0:       src_ready = 1'b1;
            1:       src_ready = ($urandom_range(0, 3) != 0);
            default: src_ready = 1'b0;
        endcase
    endtask

    // Sample just after the falling edge, let the rising edge act, then re-drive.
    task automatic tick();
        obeat_t        ob, e;
        logic [CH-1:0] cfire;
        #1;
        cyc++;
        if (src_valid === 1'b1) any_vld = 1'b1;
        cfire = ch_valid & ch_ready;
        if (src_valid === 1'b1 && src_ready === 1'b1) begin
            ob = {src_data, src_sop, src_eop, src_channel};
            beats_seen++;
            seen_ch[src_channel]++;
            if (src_sop) begin
                sop_order.push_back(int'(src_channel));
                if (gap_chk && last_eop_cyc >= 0) chk("gap", 64'(cyc - last_eop_cyc), 64'd2);
            end
            if (src_eop) last_eop_cyc = cyc;
            if (expq.size() == 0) begin
                chk("sb_extra", 64'(beats_seen), 64'(exp_total));
            end else begin
                e = expq.pop_front();
                chk("sb_beat", 64'(ob), 64'(e));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) begin
            if (cfire[k] === 1'b1 && chq[k].size() > 0) void'(chq[k].pop_front());
        end
        drive();
        @(negedge clk);
    endtask

    task automatic run(string tag, int max_cyc);
        int n = 0;
        while (expq.size() > 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk({"done_", tag}, 64'(expq.size()), 64'd0);
        repeat (8) tick();
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; beats_seen = 0; exp_total = 0;
        m_last = CH - 1; m_trunc = 0; m_drop = 0;
        for (int k = 0; k < CH; k++) begin m_pkt[k] = 0; seen_ch[k] = 0; end
        last_eop_cyc = -1; gap_chk = 1'b0; any_vld = 1'b0;
        en = '1; rdy_mode = 0; reset = 1'b1;
        drive();
        repeat (3) tick();

        chk("rst_vld", 64'(src_valid), 64'd0);
        chk("rst_sop", 64'(src_sop), 64'd0);
        chk("rst_eop", 64'(src_eop), 64'd0);
        chk("rst_data", 64'(src_data), 64'd0);
        chk("rst_chan", 64'(src_channel), 64'd0);
        chk("rst_rdy", 64'(ch_ready), 64'd0);
        chk("rst_trunc", 64'(trunc_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        for (int k = 0; k < CH; k++) chk("rst_pkt", 64'(pkt_count[k*32 +: 32]), 64'd0);
        reset = 1'b0;
        tick();

        // Four 3-beat packets, full throughput, order 0..3.
        gap_chk = 1'b1; last_eop_cyc = -1;
        for (int k = 0; k < CH; k++) add_pkt(k, 3);
        b0 = beats_seen; s0 = sop_order.size();
        predict();
        run("t30", 200);
        gap_chk = 1'b0;
        chk("t30_beats", 64'(beats_seen - b0), 64'd12);
        for (int k = 0; k < CH; k++) begin
            chk("t30_pkt", 64'(pkt_count[k*32 +: 32]), 64'd1);
            chk("t30_order", 64'(sop_order[s0 + k]), 64'(k));
        end

        // Sink stall for 5 cycles mid-packet.
        add_pkt(1, 4);
        b0 = beats_seen;
        predict();
        t = 0;
        while (beats_seen < b0 + 2 && t < 50) begin tick(); t++; end
        chk("t31_reach", 64'(beats_seen - b0), 64'd2);
        rdy_mode = 2; src_ready = 1'b0;
        #1;
        snap_d = src_data; snap_s = src_sop; snap_e = src_eop;
        chk("t31_vld", 64'(src_valid), 64'd1);
        repeat (5) begin
            tick();
            chk("t31_data", 64'(src_data), 64'(snap_d));
            chk("t31_sop", 64'(src_sop), 64'(snap_s));
            chk("t31_eop", 64'(src_eop), 64'(snap_e));
            chk("t31_rdy", 64'(ch_ready), 64'd0);
        end
        rdy_mode = 0;
        run("t31", 50);
        chk("t31_beats", 64'(beats_seen - b0), 64'd4);

        // Oversized packet on channel 2 is truncated, then channel 3 follows.
        add_pkt(2, 6); add_pkt(3, 2);
        b2 = seen_ch[2];
        predict();
        run("t32", 100);
        chk("t32_trunc", 64'(trunc_count), 64'd1);
        chk("t32_ch2_beats", 64'(seen_ch[2] - b2), 64'd4);
        chk("t32_next", 64'(sop_order[$]), 64'd3);
        chk("t32_drained", 64'(chq[2].size()), 64'd0);

        // Orphan beat in IDLE is dropped.
        any_vld = 1'b0;
        chq[1].push_back({32'hDEAD_BEEF, 1'b0, 1'b1});
        predict();
        repeat (6) tick();
        chk("t33_drop", 64'(drop_count), 64'd1);
        chk("t33_novld", 64'(any_vld), 64'd0);
        chk("t33_gone", 64'(chq[1].size()), 64'd0);

        // Enable mask 0101: only channels 0 and 2, alternating.
        en = 4'b0101;
        for (int k = 0; k < CH; k++) p0[k] = int'(pkt_count[k*32 +: 32]);
        for (int k = 0; k < CH; k++) begin
            add_pkt(k, $urandom_range(1, 3));
            add_pkt(k, $urandom_range(1, 3));
        end
        s0 = sop_order.size();
        predict();
        rdy_mode = 1;
        run("t34", 400);
        for (int i = 0; i < 4; i++) chk("t34_order", 64'(sop_order[s0 + i]), 64'((i % 2) * 2));
        chk("t34_cnt0", 64'(int'(pkt_count[31:0]) - p0[0]), 64'd2);
        chk("t34_cnt1", 64'(int'(pkt_count[63:32]) - p0[1]), 64'd0);
        chk("t34_cnt2", 64'(int'(pkt_count[95:64]) - p0[2]), 64'd2);
        chk("t34_cnt3", 64'(int'(pkt_count[127:96]) - p0[3]), 64'd0);
        chq[1].delete(); chq[3].delete();
        en = '1; rdy_mode = 0;
        drive();

        // Randomized rounds with random sink backpressure.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < CH; k++) begin
                repeat ($urandom_range(1, 2)) add_pkt(k, $urandom_range(1, 6));
            end
            predict();
            rdy_mode = 1;
            run("rand", 1500);
            for (int k = 0; k < CH; k++) chk("rand_q", 64'(chq[k].size()), 64'd0);
        end
        rdy_mode = 0;
        for (int k = 0; k < CH; k++) chk("rand_pkt", 64'(pkt_count[k*32 +: 32]), 64'(m_pkt[k]));
        chk("rand_trunc", 64'(trunc_count), 64'(m_trunc));
        chk("rand_drop", 64'(drop_count), 64'(m_drop));

        // Reset on beat 2 abandons the packet; next search starts at channel 0.
        add_pkt(2, 3);
        b0 = beats_seen;
        predict();
        t = 0;
        while (beats_seen < b0 + 1 && t < 50) begin tick(); t++; end
        reset = 1'b1;
        tick();
        chk("t35_vld", 64'(src_valid), 64'd0);
        chk("t35_rdy", 64'(ch_ready), 64'd0);
        chk("t35_trunc", 64'(trunc_count), 64'd0);
        chk("t35_drop", 64'(drop_count), 64'd0);
        for (int k = 0; k < CH; k++) chk("t35_pkt", 64'(pkt_count[k*32 +: 32]), 64'd0);
        for (int k = 0; k < CH; k++) begin chq[k].delete(); m_pkt[k] = 0; end
        expq.delete();
        exp_total = beats_seen;
        m_last = CH - 1; m_trunc = 0; m_drop = 0;
        tick();
        reset = 1'b0;
        add_pkt(3, 2); add_pkt(1, 2); add_pkt(0, 2);
        s0 = sop_order.size();
        predict();
        run("t35", 100);
        chk("t35_first", 64'(sop_order[s0]), 64'd0);
        for (int k = 0; k < CH; k++) chk("t35_cnt", 64'(pkt_count[k*32 +: 32]), 64'(m_pkt[k]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mspe_egress_arb.md
MSPE_EGRESS_ARB -- requirements
Module: mspe_egress_arb

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of per-core source channels, 1..16.
REQ-002 SHALL have parameter DATA_W, default 512: beat width in bits.
REQ-003 SHALL have parameter MAX_BEATS, default 256: maximum beats per output packet, at least 2.
REQ-004 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ch_data, input, CHANNELS*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have ports ch_valid, ch_sop, ch_eop, input, CHANNELS each: per-channel show-ahead head beat qualifiers.
REQ-008 SHALL have port ch_ready, output, CHANNELS: head beat consumed when ch_valid[k] & ch_ready[k].
REQ-009 SHALL have port ch_enable, input, CHANNELS: arbitration mask.
REQ-010 SHALL have ports src_data (DATA_W), src_valid, src_sop, src_eop, output: Avalon-ST source.
REQ-011 SHALL have port src_channel, output, max(1,$clog2(CHANNELS)): channel of the current beat.
REQ-012 SHALL have port src_ready, input, 1: sink accepts when src_valid & src_ready.
REQ-013 SHALL have port pkt_count, output, CHANNELS*32: packets emitted per channel, wrapping.
REQ-014 SHALL have ports trunc_count and drop_count, output, 16 each: saturating error counters.

Function
REQ-015 SHALL use states IDLE, XFER and DRAIN, plus grant index g and round-robin pointer last.
REQ-016 In IDLE, SHALL select the first k, searching last+1, last+2, ... modulo CHANNELS, with ch_valid[k] & ch_sop[k] & ch_enable[k]; then set g=k and last=k, and enter XFER the next cycle; no beat is consumed in the selection cycle.
REQ-017 In IDLE with no sop candidate, SHALL discard one orphan beat (enabled, valid, not sop) of the lowest-index such channel per cycle via ch_ready, and increment drop_count.
REQ-018 The output stage SHALL be a single register: load_ok = !src_valid | src_ready.
REQ-019 In XFER, ch_ready[g] SHALL equal load_ok, and all other ch_ready bits SHALL be 0; ch_ready SHALL be combinational from state, g and src_ready.
REQ-020 On an accepted beat in XFER, SHALL register ch_data[g] into src_data and set src_valid=1 and src_channel=g; src_sop=1 only on the packet's first beat; src_eop=ch_eop[g].
REQ-021 If load_ok is true and no beat is accepted, SHALL clear src_valid; src_valid SHALL otherwise hold with src_data stable while !src_ready.
REQ-022 SHALL count beats per packet; if the beat at count MAX_BEATS-1 has ch_eop=0, SHALL force src_eop=1, increment trunc_count and enter DRAIN.
REQ-023 In DRAIN, ch_ready[g] SHALL be 1 unconditionally, beats SHALL be discarded, and SHALL return to IDLE after the beat with ch_eop=1 is consumed.
REQ-024 On an accepted beat with src_eop=1 (natural or forced), SHALL increment pkt_count[g] and, for a natural eop, return to IDLE.
REQ-025 A single-beat packet (sop & eop) SHALL be accepted as a complete packet.
REQ-026 Deasserting ch_enable[g] mid-packet SHALL NOT abort the packet; the mask applies at selection only.
REQ-027 Beat latency from ch accept to src_valid SHALL be 1 cycle; full throughput SHALL be 1 beat/cycle while src_ready=1 and ch_valid[g]=1.

Reset
REQ-028 On reset, SHALL set state=IDLE, g=0, last=CHANNELS-1, src_valid=0, src_sop=0, src_eop=0, src_data=0, src_channel=0, ch_ready=0, and all counters 0.
REQ-029 Reset mid-packet SHALL abandon the packet without emitting eop; the next selection SHALL search from channel 0.

Verification
REQ-030 SHALL verify: CHANNELS=4, channels 0..3 each offer a 3-beat packet, src_ready=1 -> order 0,1,2,3, 12 beats, one idle cycle between packets, pkt_count=1 each.
REQ-031 SHALL verify: src_ready held low 5 cycles mid-packet -> src_data/src_sop/src_eop stable, ch_ready[g]=0, no beat lost or duplicated.
REQ-032 SHALL verify: MAX_BEATS=4, 6-beat packet on channel 2 -> 4 beats out with eop on beat 4, trunc_count=1, 2 beats drained, next packet is from channel 3.
REQ-033 SHALL verify: orphan non-sop beat on channel 1 in IDLE -> discarded, drop_count=1, no src_valid.
REQ-034 SHALL verify: ch_enable=4'b0101 with all channels offering packets -> only channels 0 and 2 are served, alternately.
REQ-035 SHALL verify: reset asserted on beat 2 of a packet -> next cycle src_valid=0, counters 0; after release, a packet on channel 0 is selected first.
